// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide definitions for the fetch front end.
//   XLEN          - datapath width.
//   NOP_INST      - instruction word driven when nothing is presented (bubble).
//   fetch_state_t - fetch request FSM states.
//   fetch_entry_t - one buffered fetch result {pc, inst}.
//   next_word()   - sequential word address (wraps mod 2^XLEN).
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO holding fetched {pc, inst} pairs.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset.
//   i_push, i_data - write one entry (ignored when full and not popping).
//   i_pop          - drop the head entry (ignored when empty).
//   i_flush        - empty the FIFO; wins over push and pop.
//   o_count        - number of valid entries, 0..2.
//   o_head         - oldest entry (don't-care when o_count == 0).
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  // Qualify push/pop against occupancy so the pointers can never run past each other.
  always_comb begin
    w_do_pop  = i_pop & (r_count != 2'd0);
    w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end. Owns the fetch PC, issues one
// outstanding imem read at a time, buffers returns in a 2-entry FIFO and
// presents {pc, inst} to IF/ID (zero instruction when nothing is buffered).
// Ports:
//   clk_i, rst_i             - clock, asynchronous active-low reset.
//   stall_i                  - hold the presented entry this cycle.
//   redirect_i, redirect_pc_i- flush and restart fetch at redirect_pc_i.
//   imem_req_o, imem_addr_o  - read request / address (address = fetch PC).
//   imem_ack_i               - request accepted.
//   imem_rvalid_i, imem_rdata_i - read return.
//   pc_o, pc4_o, inst_o, valid_o - presented instruction.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic         r_kill;
  logic         w_kill_nxt;

  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;
  logic         w_req;
  logic         w_valid;
  logic         w_push;
  logic         w_pop;
  logic         w_return;
  logic [31:0]  w_pc;

  // Request, presentation and FIFO control, all decoded from registered state
  // (plus stall/redirect for the FIFO only, never for an output).
  always_comb begin
    w_req       = (r_state == REQ) & (w_count < 2'd2);
    w_valid     = (w_count != 2'd0);
    w_return    = (r_state == WAIT) & imem_rvalid_i;
    w_push      = w_return & ~r_kill & ~redirect_i;
    w_pop       = w_valid & ~stall_i & ~redirect_i;
    w_push_data = '{pc: r_fetch_pc, inst: imem_rdata_i};
  end

  // Next-state logic for the request FSM, fetch PC and kill flag.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ: begin
        if (w_req && imem_ack_i) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = REQ;
    endcase

    if (redirect_i) begin
      w_fetch_pc_nxt = redirect_pc_i;
    end else if (w_push) begin
      w_fetch_pc_nxt = next_word(r_fetch_pc);
    end else begin
      w_fetch_pc_nxt = r_fetch_pc;
    end

    // A redirect that leaves a read in flight (including one acked this very
    // cycle) must discard that read's return; any return clears the flag.
    w_kill_nxt = (redirect_i & (w_state_nxt == WAIT)) | (r_kill & ~w_return);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  fetch_buf u_fetch_buf (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Output muxing: an empty FIFO presents pc 0 and a NOP bubble.
  always_comb begin
    if (w_valid) begin
      w_pc   = w_head.pc;
      inst_o = w_head.inst;
    end else begin
      w_pc   = 32'h0000_0000;
      inst_o = NOP_INST;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = w_valid;
  assign pc_o        = w_pc;
  assign pc4_o       = next_word(w_pc);

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Inputs change 1 ns after the rising edge;
// outputs are sampled in the same window, away from the edge.
module tb_if_fetch;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic [31:0] inst_o;
  logic        valid_o;

  int vectors;
  int miscompares;
  logic [129:0] exp_v;
  wire  [129:0] obs_v = {imem_req_o, imem_addr_o, valid_o, pc_o, pc4_o, inst_o};

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Expected snapshot {req, addr, valid, pc, pc+4, inst}.
  function automatic logic [129:0] mk(input logic req, input logic [31:0] addr,
                                      input logic v, input logic [31:0] pc,
                                      input logic [31:0] inst);
    return {req, addr, v, pc, pc + 32'd4, inst};
  endfunction

  // Apply one cycle of inputs, then move to 1 ns after the next rising edge.
  task automatic drive(input logic ack, input logic rv, input logic [31:0] data,
                       input logic stall, input logic redir, input logic [31:0] rpc);
    imem_ack_i    = ack;
    imem_rvalid_i = rv;
    imem_rdata_i  = data;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    exp_v = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL reset_hold: got %h required %h", obs_v, exp_v); miscompares++; end
    rst_i = 1'b1;
    #1;
    exp_v = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL reset_release: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  task automatic test_zero_wait;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL zw_wait0: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h4, 1'b1, 32'h0, 32'h2008_0005); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL zw_present0: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'h4, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL zw_wait4: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b0, 1'b1, 32'h8C09_0004, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h8, 1'b1, 32'h4, 32'h8C09_0004); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL zw_present4: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  task automatic test_stall;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'h10, 1'b1, 32'h8, 32'h1111_1111); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL st_full: got %h required %h", obs_v, exp_v); miscompares++; end
    // ack and a stray rvalid while full/REQ must change nothing
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    end
    exp_v = mk(1'b0, 32'h10, 1'b1, 32'h8, 32'h1111_1111); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL st_hold: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h10, 1'b1, 32'hC, 32'h2222_2222); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL st_release: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'h10, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL st_drain: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  task automatic test_redirect_wait;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    exp_v = mk(1'b0, 32'h40, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL rd_flush: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b0, 1'b1, 32'hBADB_AD01, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h40, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL rd_killed: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h44, 1'b1, 32'h40, 32'h3333_3333); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL rd_target: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  task automatic test_simultaneous;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'h48, 1'b1, 32'h40, 32'h3333_3333); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_full: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    exp_v = mk(1'b1, 32'h80, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_full_redir: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h84, 1'b1, 32'h80, 32'h5555_5555); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_one: got %h required %h", obs_v, exp_v); miscompares++; end
    // redirect + stall + ack of a real request: acked read must be killed
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC0);
    exp_v = mk(1'b0, 32'hC0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_ack_redir: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'hC0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_killed: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'hC4, 1'b1, 32'hC0, 32'h6666_6666); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL sim_resume: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b0, 32'hC4, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL mr_wait: got %h required %h", obs_v, exp_v); miscompares++; end
    imem_ack_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    exp_v = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL mr_async: got %h required %h", obs_v, exp_v); miscompares++; end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    drive(1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL mr_stray: got %h required %h", obs_v, exp_v); miscompares++; end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    exp_v = mk(1'b1, 32'h4, 1'b1, 32'h0, 32'h7777_7777); vectors++;
    if (obs_v !== exp_v) begin $display("FAIL mr_first: got %h required %h", obs_v, exp_v); miscompares++; end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_simultaneous();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
